// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction memory request/acknowledge bus
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  // Fetch unit side: issues the request and address, receives ack and word
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  // Memory side: accepts the request and returns the word with ack
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and BOOT/FETCH/EXEC fetch sequencer (option: ALIGN_CHECK_EN)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] nextpc,
  input  logic        stall,
  pc_fetch_unit_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] insOut,
  output logic        ins_valid,
  output logic [31:0] icount,
  output logic        align_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ins_q, ins_d;
  logic        valid_q, valid_d;
  logic [31:0] icount_q, icount_d;
  logic        aerr_q, aerr_d;
  logic [31:0] target_pc;
  logic        target_err;

  // Resolve the pc taken at EXEC exit; low address bits are never kept
`ifdef ALIGN_CHECK_EN
  always_comb begin
    target_err = (nextpc[1:0] != 2'b00);
    target_pc  = target_err ? EXC_VECTOR : nextpc;
  end
`else
  logic unused_exc_vector;
  assign unused_exc_vector = ^EXC_VECTOR;

  always_comb begin
    target_err = 1'b0;
    target_pc  = nextpc & ~32'h0000_0003;
  end
`endif

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    ins_d    = ins_q;
    valid_d  = valid_q;
    icount_d = icount_q;
    aerr_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      FETCH: begin
        // Stall is deliberately ignored here; only the ack moves us on
        if (imem.imem_ack) begin
          ins_d   = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          pc_d     = target_pc;
          addr_d   = target_pc;
          icount_d = icount_q + 32'd1;
          aerr_d   = target_err;
          valid_d  = 1'b0;
          ins_d    = NOP_WORD;
          req_d    = 1'b1;
          state_d  = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      ins_q    <= NOP_WORD;
      valid_q  <= 1'b0;
      icount_q <= 32'd0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      ins_q    <= ins_d;
      valid_q  <= valid_d;
      icount_q <= icount_d;
      aerr_q   <= aerr_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign pc             = pc_q;
  assign insOut         = ins_q;
  assign ins_valid      = valid_q;
  assign icount         = icount_q;
  assign align_err      = aerr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic [31:0] nextpc;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] insOut;
  logic        ins_valid;
  logic [31:0] icount;
  logic        align_err;

  int passes;
  int total;
  logic [31:0] exp_pc;
  logic [31:0] exp_ins;
  logic [31:0] exp_icount;

  pc_fetch_unit_if imem ();

  pc_fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nextpc    (nextpc),
    .stall     (stall),
    .imem      (imem.master),
    .pc        (pc),
    .insOut    (insOut),
    .ins_valid (ins_valid),
    .icount    (icount),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one fetch at exp_pc with the given number of wait cycles
  task automatic do_fetch(input logic [31:0] word, input int waits, input logic stall_in);
    for (int w = 0; w < waits; w++) begin
      check("wait_req", {31'd0, imem.imem_req}, 32'd1);
      check("wait_addr", imem.imem_addr, exp_pc);
      tick();
    end
    check("fetch_req", {31'd0, imem.imem_req}, 32'd1);
    check("fetch_addr", imem.imem_addr, exp_pc);
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = word;
    stall           = stall_in;
    tick();
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'hDEAD_BEEF;
    exp_ins = word;
    check("exec_valid", {31'd0, ins_valid}, 32'd1);
    check("exec_ins", insOut, exp_ins);
    check("exec_req", {31'd0, imem.imem_req}, 32'd0);
  endtask

  // Hold EXEC for stall_cycles, then retire with the given nextpc
  task automatic do_exec(input logic [31:0] npc, input int stall_cycles, input logic [31:0] want_pc);
    stall  = 1'b1;
    nextpc = 32'h0000_999C;
    for (int s = 0; s < stall_cycles; s++) begin
      tick();
      check("stall_pc", pc, exp_pc);
      check("stall_ins", insOut, exp_ins);
      check("stall_icount", icount, exp_icount);
      check("stall_valid", {31'd0, ins_valid}, 32'd1);
    end
    stall  = 1'b0;
    nextpc = npc;
    tick();
    exp_pc     = want_pc;
    exp_icount = exp_icount + 32'd1;
    check("ret_pc", pc, exp_pc);
    check("ret_addr", imem.imem_addr, exp_pc);
    check("ret_req", {31'd0, imem.imem_req}, 32'd1);
    check("ret_valid", {31'd0, ins_valid}, 32'd0);
    check("ret_ins", insOut, 32'd0);
    check("ret_icount", icount, exp_icount);
  endtask

  task automatic boot();
    rst_n = 1'b1;
    check("boot_req", {31'd0, imem.imem_req}, 32'd0);
    tick();
    check("boot_fetch_req", {31'd0, imem.imem_req}, 32'd1);
    check("boot_fetch_addr", imem.imem_addr, 32'd0);
  endtask

  initial begin
    passes = 0;
    total  = 0;
    rst_n  = 1'b0;
    nextpc = 32'd0;
    stall  = 1'b0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;
    exp_pc     = 32'd0;
    exp_ins    = 32'd0;
    exp_icount = 32'd0;
    tick();
    tick();

    check("rst_req", {31'd0, imem.imem_req}, 32'd0);
    check("rst_addr", imem.imem_addr, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_ins", insOut, 32'd0);
    check("rst_valid", {31'd0, ins_valid}, 32'd0);
    check("rst_icount", icount, 32'd0);
    check("rst_aerr", {31'd0, align_err}, 32'd0);
    boot();

    // Sequential stream at 2 cycles per instruction
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", pc, 32'(i * 4));
      do_fetch(32'h2000_0000 + 32'(i), 0, 1'b0);
      do_exec(exp_pc + 32'd4, 0, exp_pc + 32'd4);
    end
    check("seq_icount", icount, 32'd4);

    // Reset asserted mid-FETCH takes effect without a clock edge
    check("midfetch_req", {31'd0, imem.imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, imem.imem_req}, 32'd0);
    check("arst_pc", pc, 32'd0);
    check("arst_valid", {31'd0, ins_valid}, 32'd0);
    check("arst_icount", icount, 32'd0);
    tick();
    exp_pc     = 32'd0;
    exp_icount = 32'd0;
    boot();

    // Wait states at address 0x10
    do_fetch(32'h0000_0001, 0, 1'b0);
    do_exec(32'h0000_0010, 0, 32'h0000_0010);
    do_fetch(32'h2108_0001, 3, 1'b0);

    // Stall for 5 EXEC cycles, then take 0x40
    do_exec(32'h0000_0040, 5, 32'h0000_0040);

    // Ack with stall high in FETCH: ack wins
    do_fetch(32'h0810_0008, 0, 1'b1);

    // Jump target
    do_exec(32'h0040_0020, 0, 32'h0040_0020);

    // Retired counter wraps from all ones
    do_fetch(32'h0000_0002, 0, 1'b0);
    stall = 1'b1;
    force dut.icount_q = 32'hFFFF_FFFF;
    tick();
    release dut.icount_q;
    tick();
    check("wrap_preload", icount, 32'hFFFF_FFFF);
    exp_icount = 32'hFFFF_FFFF;
    do_exec(32'h0000_0100, 0, 32'h0000_0100);
    check("wrap_zero", icount, 32'd0);

    // Misaligned nextpc
    do_fetch(32'h0000_0003, 0, 1'b0);
`ifdef ALIGN_CHECK_EN
    do_exec(32'h0000_0102, 0, 32'h0000_0180);
    check("mis_aerr", {31'd0, align_err}, 32'd1);
    tick();
    check("mis_aerr_pulse", {31'd0, align_err}, 32'd0);
`else
    do_exec(32'h0000_0102, 0, 32'h0000_0100);
    check("mis_aerr", {31'd0, align_err}, 32'd0);
    tick();
    check("mis_aerr_hold", {31'd0, align_err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
